// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the legal operand-width range checked at elaboration.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MIN_WIDTH = 1;
  localparam int MAX_WIDTH = 64;

  function automatic bit width_in_range(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Full subtractor cell: a - b - bin built from two half subtractors; either
// stage borrowing means the cell borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs_ab (
    .a    (a),
    .b    (b),
    .diff (d1),
    .bout (b1)
  );

  half_subtractor u_hs_bin (
    .a    (d1),
    .b    (bin),
    .diff (diff),
    .bout (b2)
  );

  assign bout = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// Half subtractor: diff = a - b, borrow out when b exceeds a.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b;
  assign bout = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b - borrow_in, LSB first, one bit per
// clock through a single full-subtractor cell and a borrow flop.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_borrow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_ovf
);

  if (!width_in_range(WIDTH)) begin : g_bad_width
    $error("serial_subtractor: WIDTH must be between 1 and 64");
  end

  localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic             borrow_q, borrow_d;
  logic             a_msb_q,  a_msb_d;
  logic             b_msb_q,  b_msb_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             bout_q,   bout_d;
  logic             ovf_q,    ovf_d;

  logic             fs_diff;
  logic             fs_bout;
  logic [WIDTH:0]   res_wide;
  logic [WIDTH-1:0] res_next;

  full_subtractor u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (borrow_q),
    .diff (fs_diff),
    .bout (fs_bout)
  );

  // New bit enters at the MSB; written this way so WIDTH=1 needs no special case.
  assign res_wide = {fs_diff, res_q};
  assign res_next = res_wide[WIDTH:1];

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch can infer a latch.
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d   = in_a;
          b_sr_d   = in_b;
          borrow_d = in_borrow;
          a_msb_d  = in_a[WIDTH-1];
          b_msb_d  = in_b[WIDTH-1];
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        borrow_d = fs_bout;
        res_d    = res_next;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          diff_d  = res_next;
          bout_d  = fs_bout;
          ovf_d   = (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_diff   = diff_q;
  assign out_borrow = bout_q;
  assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: three instances (WIDTH 8, 1, 16) checked against an
// integer-arithmetic reference model, with directed and random operations.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a_bus = '0;
  logic [15:0] b_bus = '0;
  logic        bin_bus = 1'b0;
  logic [2:0]  iv = '0;
  logic [2:0]  orr = '0;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  ob;
  logic [2:0]  oo;
  logic [7:0]  d8;
  logic [0:0]  d1;
  logic [15:0] d16;

  int n_checks = 0;
  int n_pass   = 0;
  int widths[3] = '{8, 1, 16};

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_a(a_bus[7:0]), .in_b(b_bus[7:0]), .in_borrow(bin_bus),
    .out_valid(ov[0]), .out_ready(orr[0]), .out_diff(d8),
    .out_borrow(ob[0]), .out_ovf(oo[0])
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_a(a_bus[0:0]), .in_b(b_bus[0:0]), .in_borrow(bin_bus),
    .out_valid(ov[1]), .out_ready(orr[1]), .out_diff(d1),
    .out_borrow(ob[1]), .out_ovf(oo[1])
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_a(a_bus), .in_b(b_bus), .in_borrow(bin_bus),
    .out_valid(ov[2]), .out_ready(orr[2]), .out_diff(d16),
    .out_borrow(ob[2]), .out_ovf(oo[2])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] diff_of(input int sel);
    case (sel)
      0:       return {8'b0, d8};
      1:       return {15'b0, d1};
      default: return d16;
    endcase
  endfunction

  // Reference: exact integer subtraction, then reduce to the unsigned and signed views.
  task automatic model(input int w, input longint a, input longint b, input bit bin,
                       output longint diff, output bit bout, output bit ovf);
    longint r, sa, sb, sr, half, full;
    full = longint'(1) << w;
    half = full >> 1;
    r    = a - b - longint'(bin);
    diff = r & (full - 1);
    bout = (r < 0);
    sa   = (a >= half) ? a - full : a;
    sb   = (b >= half) ? b - full : b;
    sr   = sa - sb - longint'(bin);
    ovf  = (sr < -half) || (sr > half - 1);
  endtask

  task automatic accept(input int sel, input logic [15:0] a, input logic [15:0] b, input bit bin);
    int guard = 0;
    @(negedge clk);
    a_bus = a; b_bus = b; bin_bus = bin; iv[sel] = 1'b1;
    while (!ir[sel] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!ir[sel]) check("accept_timeout", 64'(ir[sel]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    iv[sel] = 1'b0;
  endtask

  // Called at the negedge right after the accepting edge.
  task automatic wait_done(input int sel, input string tag);
    int n = 0;
    while (!ov[sel] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(widths[sel]));
  endtask

  task automatic check_result(input int sel, input logic [15:0] a, input logic [15:0] b,
                              input bit bin, input string tag);
    longint ed;
    bit eb, eo;
    model(widths[sel], longint'(a), longint'(b), bin, ed, eb, eo);
    check({tag, "_valid"},  64'(ov[sel]), 64'd1);
    check({tag, "_diff"},   64'(diff_of(sel)), 64'(ed));
    check({tag, "_borrow"}, 64'(ob[sel]), 64'(eb));
    check({tag, "_ovf"},    64'(oo[sel]), 64'(eo));
  endtask

  task automatic consume(input int sel);
    orr[sel] = 1'b1;
    @(negedge clk);
    orr[sel] = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    bit         bin;
    logic [7:0] diff;
    bit         bout;
    bit         ovf;
  } vec_t;

  vec_t vecs[4] = '{
    '{8'd200, 8'd55,  1'b0, 8'd145,  1'b0, 1'b0},
    '{8'd5,   8'd10,  1'b0, 8'd251,  1'b1, 1'b0},
    '{8'h80,  8'h01,  1'b0, 8'h7F,   1'b0, 1'b1},
    '{8'h00,  8'h00,  1'b1, 8'hFF,   1'b1, 1'b0}
  };

  initial begin
    logic [15:0] ra, rb, held;
    bit rbin;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready",  64'(ir[0]), 64'd1);
    check("rst_out_valid", 64'(ov[0]), 64'd0);
    check("rst_diff",      64'(d8), 64'd0);
    check("rst_borrow",    64'(ob[0]), 64'd0);
    check("rst_ovf",       64'(oo[0]), 64'd0);

    // Directed WIDTH=8 vectors with fixed expected values.
    foreach (vecs[i]) begin
      accept(0, {8'b0, vecs[i].a}, {8'b0, vecs[i].b}, vecs[i].bin);
      check("dir_in_ready_run", 64'(ir[0]), 64'd0);
      wait_done(0, "dir");
      check("dir_diff",   64'(d8), 64'(vecs[i].diff));
      check("dir_borrow", 64'(ob[0]), 64'(vecs[i].bout));
      check("dir_ovf",    64'(oo[0]), 64'(vecs[i].ovf));
      consume(0);
      check("dir_consumed_valid", 64'(ov[0]), 64'd0);
      check("dir_consumed_ready", 64'(ir[0]), 64'd1);
    end

    // Back-pressure: held result, new operand offered but ignored while in DONE.
    accept(0, 16'd200, 16'd55, 1'b0);
    wait_done(0, "bp1");
    held = diff_of(0);
    a_bus = 16'd5; b_bus = 16'd10; bin_bus = 1'b0; iv[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid_held", 64'(ov[0]), 64'd1);
      check("bp_ready_low",  64'(ir[0]), 64'd0);
      check("bp_diff_held",  64'(d8), 64'd145);
    end
    orr[0] = 1'b1;
    @(negedge clk);
    orr[0] = 1'b0;
    check("bp_consumed_valid", 64'(ov[0]), 64'd0);
    check("bp_not_yet_taken",  64'(ir[0]), 64'd1);
    check("bp_diff_kept",      64'(d8), 64'(held));
    @(negedge clk);
    check("bp_taken_next", 64'(ir[0]), 64'd0);
    iv[0] = 1'b0;
    wait_done(0, "bp2");
    check_result(0, 16'd5, 16'd10, 1'b0, "bp2");
    consume(0);

    // Reset during RUN at cnt=3.
    accept(0, 16'd100, 16'd33, 1'b1);
    repeat (3) @(negedge clk);
    check("abort_still_run", 64'(ov[0]), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready",  64'(ir[0]), 64'd1);
    check("abort_out_valid", 64'(ov[0]), 64'd0);
    check("abort_diff",      64'(d8), 64'd0);
    check("abort_borrow",    64'(ob[0]), 64'd0);
    check("abort_ovf",       64'(oo[0]), 64'd0);
    accept(0, 16'd100, 16'd33, 1'b1);
    wait_done(0, "post_abort");
    check("post_abort_diff", 64'(d8), 64'd66);
    consume(0);

    // WIDTH=1 exhaustive.
    for (int c = 0; c < 8; c++) begin
      ra = 16'(c & 1); rb = 16'((c >> 1) & 1); rbin = bit'((c >> 2) & 1);
      accept(1, ra, rb, rbin);
      wait_done(1, "w1");
      check_result(1, ra, rb, rbin, "w1");
      consume(1);
    end

    // WIDTH=16 random with random consumer delay.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rbin = bit'($urandom_range(0, 1));
      if (i == 0) begin ra = 16'h8000; rb = 16'h0000; rbin = 1'b1; end
      if (i == 1) begin ra = 16'hFFFF; rb = 16'hFFFF; rbin = 1'b0; end
      accept(2, ra, rb, rbin);
      wait_done(2, "rnd");
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check_result(2, ra, rb, rbin, "rnd");
      consume(2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial W-bit subtractor. Computes a - b - borrow_in, LSB first, one bit per clock, using a single full-subtractor cell and a borrow flop.
- Arithmetic counterpart to the team's full-adder cells, for area-constrained datapaths that can trade latency for gates.
- Operands arrive on a valid/ready input handshake; the result leaves on a valid/ready output handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1 to 64).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and borrow_in are valid this cycle.
- in_ready  output  1  block can accept operands (high only in IDLE).
- in_a  input  WIDTH  minuend.
- in_b  input  WIDTH  subtrahend.
- in_borrow  input  1  borrow-in.
- out_valid  output  1  result is valid (high only in DONE).
- out_ready  input  1  consumer accepts the result.
- out_diff  output  WIDTH  (a - b - borrow_in) mod 2^WIDTH.
- out_borrow  output  1  final borrow; set when the unsigned result is negative.
- out_ovf  output  1  signed (two's-complement) overflow.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high: rst is sampled on the rising edge of clk.
  - On reset: state IDLE; in_ready=1; out_valid=0; out_diff=0; out_borrow=0; out_ovf=0. Internal shift registers, counter and borrow flop are cleared.
- State machine: IDLE -> RUN -> DONE -> IDLE.
  - IDLE: in_ready=1. If in_valid is high at an edge:
    - latch a_sr<=in_a, b_sr<=in_b, borrow<=in_borrow;
    - capture a_msb=in_a[WIDTH-1] and b_msb=in_b[WIDTH-1];
    - set cnt<=0 and go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle:
    - d = a_sr[0] ^ b_sr[0] ^ borrow;
    - borrow <= (~a_sr[0] & b_sr[0]) | (~(a_sr[0]^b_sr[0]) & borrow);
    - a_sr and b_sr shift right by one;
    - the result register shifts right with d inserted at bit WIDTH-1;
    - cnt increments.
  - RUN exit: on the edge where cnt == WIDTH-1 (the last bit is processed), go to DONE.
  - DONE: out_valid=1. out_diff, out_borrow and out_ovf are held stable.
    - out_ovf = (a_msb != b_msb) && (out_diff[WIDTH-1] != a_msb).
    - When out_ready is high at an edge, go to IDLE.
    - While out_ready is low, stay in DONE indefinitely with outputs stable.
- Latency:
  - With acceptance at edge T, out_valid rises after edge T+WIDTH.
  - Throughput is one operation per WIDTH+2 cycles at best.
- Boundary conditions:
  - in_valid during RUN or DONE is ignored (in_ready=0). The producer must hold its data.
  - In DONE, out_ready and in_valid high together: the result is consumed; the new operand is not accepted that edge. It is accepted in IDLE on the next edge.
  - Reset in RUN or DONE aborts immediately to IDLE. The partial result is discarded, and out_valid is 0 on the following cycle.
  - WIDTH=1: RUN lasts exactly one cycle. Counter width is $clog2(WIDTH+1), minimum 1 bit.
  - Outputs in IDLE/RUN hold the last result (or 0 after reset); consumers must qualify them with out_valid.
- Arithmetic:
  - Result is exact modulo 2^WIDTH.
  - out_borrow equals the bit WIDTH of the (WIDTH+1)-bit value a - b - borrow_in, taken as the borrow.

Decomposition:
- Shared package: state enum typedef (IDLE, RUN, DONE) and a WIDTH range-check constant/function used by an elaboration-time assertion.
- One sub-module: full_subtractor, purely combinational.
  - Inputs: a, b, bin. Outputs: diff, bout.
  - Built from two half_subtractor instances plus an OR on the borrows.
- Top level holds the FSM, counter, shift registers and borrow flop.

Test Plan:
- WIDTH=8, a=200, b=55, bin=0 -> out_diff=145, out_borrow=0, out_ovf=0; out_valid exactly 8 cycles after acceptance.
- WIDTH=8, a=5, b=10, bin=0 -> out_diff=251, out_borrow=1, out_ovf=0.
- WIDTH=8, a=0x80, b=0x01, bin=0 -> out_diff=0x7F, out_borrow=0, out_ovf=1. Also a=0x00, b=0x00, bin=1 -> 0xFF, borrow=1, ovf=0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no new accept. On out_ready=1, the next op is accepted one cycle later.
- Assert rst for one cycle at cnt=3 of RUN -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0. A subsequent op computes correctly.
- WIDTH=1, all 8 combinations of a/b/bin -> correct diff/borrow, 1-cycle RUN. Randomised 1000 ops at WIDTH=16 checked against a reference model.
